// File: rtl/rx_frame_parser.sv
// Receive-side frame parser: packs MII nibbles into bytes, captures the Ethernet
// header and produces a per-frame verdict (FCS residue, length, nibble alignment).
module rx_frame_parser #(
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1518,
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nib_start,
    input  logic        nib_valid,
    input  logic [3:0]  nib_data,
    input  logic        nib_end,
    output logic        out_byte_valid,
    output logic [7:0]  out_byte,
    output logic [10:0] out_byte_idx,
    output logic        hdr_valid,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_crc,
    output logic        err_len,
    output logic        err_odd
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LO = 2'd1, ST_HI = 2'd2, ST_END = 2'd3} state_t;

    localparam logic [10:0] LP_MIN     = 11'(MIN_BYTES);
    localparam logic [10:0] LP_MAX     = 11'(MAX_BYTES);
    localparam logic [31:0] LP_RESIDUE = 32'hDEBB20E3;

    // Reflected CRC-32 over one byte, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    state_t        r_state;
    state_t        w_next;
    logic          r_end_d;
    logic [3:0]    r_lo;
    logic [10:0]   r_byte_cnt;
    logic [31:0]   r_crc;
    logic [111:0]  r_hdr;
    logic          r_byte_valid, r_hdr_valid, r_done, r_ok, r_err_crc, r_err_len, r_err_odd;
    logic [7:0]    r_byte;
    logic [10:0]   r_idx;

    logic          w_end_edge, w_lo_take, w_byte, w_end_take, w_odd;
    logic [7:0]    w_byte_data;
    logic [10:0]   w_cnt_next;
    logic [31:0]   w_crc_next;
    logic          w_err_crc, w_err_len;

    assign w_end_edge  = nib_end & ~r_end_d;
    assign w_byte_data = {nib_data, r_lo};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a start pulse restarts from any state
    always_comb begin
        w_next = r_state;
        if (nib_start) begin
            w_next = nib_valid ? ST_HI : ST_LO;
        end else begin
            case (r_state)
                ST_IDLE: w_next = ST_IDLE;
                ST_LO:   w_next = w_end_edge ? ST_END : (nib_valid ? ST_HI : ST_LO);
                ST_HI:   w_next = w_end_edge ? ST_END : (nib_valid ? ST_LO : ST_HI);
                ST_END:  w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Per-state decode; a nibble arriving with the end edge is consumed before the end
    always_comb begin
        w_lo_take  = 1'b0;
        w_byte     = 1'b0;
        w_end_take = 1'b0;
        w_odd      = 1'b0;
        if (nib_start) begin
            w_lo_take = nib_valid;
        end else begin
            case (r_state)
                ST_LO: begin
                    w_lo_take  = nib_valid;
                    w_end_take = w_end_edge;
                    w_odd      = nib_valid;
                end
                ST_HI: begin
                    w_byte     = nib_valid;
                    w_end_take = w_end_edge;
                    w_odd      = ~nib_valid;
                end
                default: begin
                    w_lo_take = 1'b0;
                end
            endcase
        end
    end

    // Next byte count / CRC including any byte completed this cycle
    always_comb begin
        if (w_byte) begin
            w_cnt_next = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : (r_byte_cnt + 11'd1);
            w_crc_next = crc32_byte(r_crc, w_byte_data);
        end else begin
            w_cnt_next = r_byte_cnt;
            w_crc_next = r_crc;
        end
        w_err_crc = CHECK_CRC && (w_crc_next != LP_RESIDUE);
        w_err_len = (w_cnt_next < LP_MIN) || (w_cnt_next > LP_MAX);
    end

    // Datapath: byte assembly, header shift-in, CRC, verdict flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_end_d      <= 1'b0;
            r_lo         <= 4'd0;
            r_byte_cnt   <= 11'd0;
            r_crc        <= 32'hFFFFFFFF;
            r_hdr        <= 112'd0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'd0;
            r_idx        <= 11'd0;
            r_hdr_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_ok         <= 1'b0;
            r_err_crc    <= 1'b0;
            r_err_len    <= 1'b0;
            r_err_odd    <= 1'b0;
        end else begin
            r_end_d      <= nib_end;
            r_byte_valid <= w_byte && (r_byte_cnt < LP_MAX);
            r_hdr_valid  <= w_byte && (r_byte_cnt == 11'd13);
            r_done       <= w_end_take;
            if (nib_start) begin
                r_crc      <= 32'hFFFFFFFF;
                r_byte_cnt <= 11'd0;
                r_hdr      <= 112'd0;
            end else begin
                r_crc      <= w_crc_next;
                r_byte_cnt <= w_cnt_next;
                if (w_byte && (r_byte_cnt < 11'd14)) begin
                    r_hdr <= {r_hdr[103:0], w_byte_data};
                end
            end
            if (w_lo_take) begin
                r_lo <= nib_data;
            end
            if (w_byte) begin
                r_byte <= w_byte_data;
                r_idx  <= r_byte_cnt;
            end
            if (w_end_take) begin
                r_err_crc <= w_err_crc;
                r_err_len <= w_err_len;
                r_err_odd <= w_odd;
                r_ok      <= ~(w_err_crc | w_err_len | w_odd);
            end
        end
    end

    assign out_byte_valid = r_byte_valid;
    assign out_byte       = r_byte;
    assign out_byte_idx   = r_idx;
    assign hdr_valid      = r_hdr_valid;
    assign dst_mac        = r_hdr[111:64];
    assign src_mac        = r_hdr[63:16];
    assign ethertype      = r_hdr[15:0];
    assign frame_done     = r_done;
    assign frame_ok       = r_ok;
    assign err_crc        = r_err_crc;
    assign err_len        = r_err_len;
    assign err_odd        = r_err_odd;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: builds frames with a locally computed FCS,
// drives them nibble by nibble and checks bytes, header and verdict per scenario.
module tb_rx_frame_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        nib_start = 1'b0, nib_valid = 1'b0, nib_end = 1'b0;
    logic [3:0]  nib_data = 4'd0;
    logic        out_byte_valid, hdr_valid, frame_done, frame_ok, err_crc, err_len, err_odd;
    logic [7:0]  out_byte;
    logic [10:0] out_byte_idx;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] ethertype;
    logic        obv2, hv2, fd2, ok2, ec2, el2, eo2;
    logic [7:0]  ob2;
    logic [10:0] oi2;
    logic [47:0] dm2, sm2;
    logic [15:0] et2;

    int checks = 0;
    int errors = 0;
    logic [7:0] frame [0:1599];

    int n_bytes = 0, n_hdr = 0, n_done = 0, byte_err = 0, exp_idx = 0;
    logic [10:0] hdr_idx;
    logic [15:0] hdr_et;
    logic [47:0] hdr_dst, hdr_src;
    logic v_ok, v_crc, v_len, v_odd, v2_ok, v2_crc;

    always #5 clk = ~clk;

    rx_frame_parser dut (
        .clk(clk), .reset(reset), .nib_start(nib_start), .nib_valid(nib_valid),
        .nib_data(nib_data), .nib_end(nib_end), .out_byte_valid(out_byte_valid),
        .out_byte(out_byte), .out_byte_idx(out_byte_idx), .hdr_valid(hdr_valid),
        .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
        .frame_done(frame_done), .frame_ok(frame_ok), .err_crc(err_crc),
        .err_len(err_len), .err_odd(err_odd)
    );

    rx_frame_parser #(.CHECK_CRC(1'b0)) dut_nocrc (
        .clk(clk), .reset(reset), .nib_start(nib_start), .nib_valid(nib_valid),
        .nib_data(nib_data), .nib_end(nib_end), .out_byte_valid(obv2),
        .out_byte(ob2), .out_byte_idx(oi2), .hdr_valid(hv2),
        .dst_mac(dm2), .src_mac(sm2), .ethertype(et2),
        .frame_done(fd2), .frame_ok(ok2), .err_crc(ec2),
        .err_len(el2), .err_odd(eo2)
    );

    // Observe DUT on the falling edge: byte sequence, header, verdict
    always @(negedge clk) begin
        if (nib_start) begin
            exp_idx <= 0;
        end else if (out_byte_valid) begin
            n_bytes <= n_bytes + 1;
            if (out_byte_idx !== exp_idx[10:0] || out_byte !== frame[exp_idx]) byte_err <= byte_err + 1;
            exp_idx <= exp_idx + 1;
        end
        if (hdr_valid) begin
            n_hdr   <= n_hdr + 1;
            hdr_idx <= out_byte_idx;
            hdr_et  <= ethertype;
            hdr_dst <= dst_mac;
            hdr_src <= src_mac;
        end
        if (frame_done) begin
            n_done <= n_done + 1;
            v_ok   <= frame_ok;
            v_crc  <= err_crc;
            v_len  <= err_len;
            v_odd  <= err_odd;
            v2_ok  <= ok2;
            v2_crc <= ec2;
        end
    end

    task automatic build_frame(input int len, input bit corrupt);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            if (i < 6)        frame[i] = 8'hFF;
            else if (i < 12)  frame[i] = 8'(17 * (i - 6));
            else if (i == 12) frame[i] = 8'h08;
            else if (i == 13) frame[i] = 8'h00;
            else              frame[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < len - 4; i++) begin
            c = c ^ {24'd0, frame[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        frame[len-4] = c[7:0];
        frame[len-3] = c[15:8];
        frame[len-2] = c[23:16];
        frame[len-1] = c[31:24];
        if (corrupt) frame[len-1] = frame[len-1] ^ 8'h01;
    endtask

    // Drives a frame; leaves nib_end high unless aborted after abort_at bytes
    task automatic send_frame(input int nbytes, input bit slow, input bit extra, input int abort_at);
        nib_start = 1'b1; nib_valid = 1'b0;
        @(posedge clk); #1;
        nib_start = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            if (abort_at > 0 && i == abort_at) return;
            for (int h = 0; h < 2; h++) begin
                nib_valid = 1'b1;
                nib_data  = (h == 1) ? frame[i][7:4] : frame[i][3:0];
                @(posedge clk); #1;
                if (slow) begin
                    nib_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
        end
        if (extra) begin
            nib_valid = 1'b1; nib_data = 4'hA;
            @(posedge clk); #1;
        end
        nib_valid = 1'b0;
        nib_end   = 1'b1;
    endtask

    task automatic close_frame();
        repeat (3) @(posedge clk);
        #1 nib_end = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (out_byte_valid !== 1'b0 || frame_done !== 1'b0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b%b want 000", out_byte_valid, frame_done, hdr_valid); end
        checks++; if ({frame_ok, err_crc, err_len, err_odd} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {frame_ok, err_crc, err_len, err_odd}); end
        checks++; if (dst_mac !== 48'd0 || ethertype !== 16'd0 || out_byte_idx !== 11'd0) begin errors++; $display("FAIL reset_data: got %h %h %h want 0", dst_mac, ethertype, out_byte_idx); end
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_good_frame(input bit slow);
        int b0, h0, d0, e0;
        b0 = n_bytes; h0 = n_hdr; d0 = n_done; e0 = byte_err;
        build_frame(64, 1'b0);
        send_frame(64, slow, 1'b0, 0);
        @(posedge clk); @(negedge clk);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL good_done_latency slow=%0d: got %b want 1", slow, frame_done); end
        close_frame();
        checks++; if (n_bytes - b0 !== 64) begin errors++; $display("FAIL good_bytes slow=%0d: got %0d want 64", slow, n_bytes - b0); end
        checks++; if (byte_err - e0 !== 0) begin errors++; $display("FAIL good_byte_seq slow=%0d: got %0d bad want 0", slow, byte_err - e0); end
        checks++; if (n_hdr - h0 !== 1 || hdr_idx !== 11'd13) begin errors++; $display("FAIL good_hdr slow=%0d: got n=%0d idx=%0d want 1/13", slow, n_hdr - h0, hdr_idx); end
        checks++; if (hdr_et !== 16'h0800 || hdr_src !== 48'h001122334455 || hdr_dst !== 48'hFFFFFFFFFFFF) begin errors++; $display("FAIL good_hdr_fields: got %h %h %h", hdr_dst, hdr_src, hdr_et); end
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL good_done_count: got %0d want 1", n_done - d0); end
        checks++; if ({v_ok, v_crc, v_len, v_odd} !== 4'b1000) begin errors++; $display("FAIL good_verdict: got %b want 1000", {v_ok, v_crc, v_len, v_odd}); end
    endtask

    task automatic test_bad_crc();
        build_frame(64, 1'b1);
        send_frame(64, 1'b0, 1'b0, 0);
        close_frame();
        checks++; if ({v_ok, v_crc, v_len, v_odd} !== 4'b0100) begin errors++; $display("FAIL crc_verdict: got %b want 0100", {v_ok, v_crc, v_len, v_odd}); end
        checks++; if ({v2_ok, v2_crc} !== 2'b10) begin errors++; $display("FAIL crc_disabled: got %b want 10", {v2_ok, v2_crc}); end
    endtask

    task automatic test_odd();
        int b0;
        b0 = n_bytes;
        build_frame(64, 1'b0);
        send_frame(64, 1'b0, 1'b1, 0);
        close_frame();
        checks++; if (n_bytes - b0 !== 64) begin errors++; $display("FAIL odd_bytes: got %0d want 64", n_bytes - b0); end
        checks++; if ({v_ok, v_crc, v_len, v_odd} !== 4'b0001) begin errors++; $display("FAIL odd_verdict: got %b want 0001", {v_ok, v_crc, v_len, v_odd}); end
    endtask

    task automatic test_short();
        int b0, h0;
        b0 = n_bytes; h0 = n_hdr;
        build_frame(40, 1'b0);
        send_frame(40, 1'b0, 1'b0, 0);
        close_frame();
        checks++; if (n_bytes - b0 !== 40 || n_hdr - h0 !== 1) begin errors++; $display("FAIL short_counts: got %0d/%0d want 40/1", n_bytes - b0, n_hdr - h0); end
        checks++; if ({v_ok, v_crc, v_len, v_odd} !== 4'b0010) begin errors++; $display("FAIL short_verdict: got %b want 0010", {v_ok, v_crc, v_len, v_odd}); end
    endtask

    task automatic test_long();
        int b0, e0;
        b0 = n_bytes; e0 = byte_err;
        build_frame(1600, 1'b0);
        send_frame(1600, 1'b0, 1'b0, 0);
        close_frame();
        checks++; if (n_bytes - b0 !== 1518 || byte_err - e0 !== 0) begin errors++; $display("FAIL long_bytes: got %0d (bad %0d) want 1518", n_bytes - b0, byte_err - e0); end
        checks++; if ({v_ok, v_crc, v_len, v_odd} !== 4'b0010) begin errors++; $display("FAIL long_verdict: got %b want 0010", {v_ok, v_crc, v_len, v_odd}); end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = n_done;
        build_frame(64, 1'b0);
        send_frame(64, 1'b0, 1'b0, 20);
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({out_byte_valid, hdr_valid, frame_done, frame_ok, err_crc, err_len, err_odd} !== 7'd0 || out_byte !== 8'd0 || out_byte_idx !== 11'd0 || src_mac !== 48'd0) begin errors++; $display("FAIL midreset_outputs: got %b %h %h %h", {out_byte_valid, hdr_valid, frame_done, frame_ok, err_crc, err_len, err_odd}, out_byte, out_byte_idx, src_mac); end
        repeat (2) @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (n_done - d0 !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", n_done - d0); end
        send_frame(64, 1'b0, 1'b0, 0);
        close_frame();
        checks++; if (n_done - d0 !== 1 || v_ok !== 1'b1) begin errors++; $display("FAIL midreset_next: got done=%0d ok=%b want 1/1", n_done - d0, v_ok); end
    endtask

    task automatic test_restart();
        int d0, b0, e0;
        d0 = n_done; e0 = byte_err;
        build_frame(64, 1'b0);
        send_frame(64, 1'b0, 1'b0, 20);
        b0 = n_bytes;
        send_frame(64, 1'b0, 1'b0, 0);
        close_frame();
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", n_done - d0); end
        checks++; if (n_bytes - b0 !== 64 || byte_err - e0 !== 0) begin errors++; $display("FAIL restart_bytes: got %0d (bad %0d) want 64", n_bytes - b0, byte_err - e0); end
        checks++; if ({v_ok, v_crc, v_len, v_odd} !== 4'b1000) begin errors++; $display("FAIL restart_verdict: got %b want 1000", {v_ok, v_crc, v_len, v_odd}); end
    endtask

    initial begin
        test_reset();
        test_good_frame(1'b0);
        test_bad_crc();
        test_odd();
        test_short();
        test_long();
        test_good_frame(1'b1);
        test_reset_mid();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
